dsi_hs_lane_rx: RTL

Receive-side counterpart of the DSI high-speed data lane transmitter. It accepts unaligned parallel bytes from the lane deserializer while the line is in HS mode. It hunts for the SoT sync byte at any bit offset, locks byte alignment and emits aligned payload bytes. When HS mode ends, it discards the trail bytes and signals end-of-transmission. It sits between the per-lane deserializer/LP-detect logic and the lane merger/packet parser.

---
 rtl/dsi_phy_pkg.sv | 19 +
 rtl/dsi_sync_finder.sv | 33 +++
 rtl/dsi_hs_lane_rx.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/dsi_phy_pkg.sv
`default_nettype none
// ============================================================
// Package : dsi_phy_pkg
// Brief   : Shared DSI PHY lane constants and rx state encoding
// Revision: 1.0
// ============================================================
package dsi_phy_pkg;

  localparam logic [7:0] SYNC_SEQUENCE = 8'h1D;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_HUNT   = 2'd1,
    RX_ACTIVE = 2'd2,
    RX_ERR    = 2'd3
  } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/dsi_sync_finder.sv
`default_nettype none
// ============================================================
// Module  : dsi_sync_finder
// Brief   : Locates the first set bit of prev_q and tests for SoT sync there
// Revision: 1.0
// ============================================================
module dsi_sync_finder
  import dsi_phy_pkg::*;
(
  input  logic [7:0] prev_q,
  input  logic [7:0] hs_input,
  output logic       found,
  output logic       mismatch,
  output logic [2:0] offset
);

  logic [15:0] window;
  logic [7:0]  cand;

  always_comb begin
    window = {hs_input, prev_q};
    offset = 3'd0;
    // Descending scan so the lowest set bit wins.
    for (int i = 7; i >= 0; i--) begin
      if (prev_q[i]) offset = i[2:0];
    end
    cand     = window[offset +: 8];
    found    = (prev_q != 8'd0) && (cand == SYNC_SEQUENCE);
    mismatch = (prev_q != 8'd0) && (cand != SYNC_SEQUENCE);
  end

endmodule
`default_nettype wire

// File: rtl/dsi_hs_lane_rx.sv
`default_nettype none
// ============================================================
// Module  : dsi_hs_lane_rx
// Brief   : DSI HS data-lane receiver: SoT hunt, byte alignment, trail strip
// Revision: 1.0
// ============================================================
module dsi_hs_lane_rx
  import dsi_phy_pkg::*;
#(
  parameter int TRAIL_BYTES  = 1,
  parameter int HUNT_TIMEOUT = 16
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic [7:0] hs_input,
  input  logic       hs_valid,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_sot,
  output logic       rx_eot,
  output logic       rx_sot_err,
  output logic       active,
  output logic [7:0] sot_err_cnt
);

  localparam int CNT_W = (HUNT_TIMEOUT < 2) ? 1 : $clog2(HUNT_TIMEOUT);
  localparam logic [CNT_W-1:0] HUNT_LAST = CNT_W'(HUNT_TIMEOUT - 1);
  localparam int HB_W = 8 * TRAIL_BYTES;

  rx_state_e              state_q, state_d;
  logic [7:0]             prev_q, prev_d;
  logic [2:0]             off_q, off_d;
  logic [CNT_W-1:0]       hunt_cnt_q, hunt_cnt_d;
  logic [HB_W-1:0]        hb_data_q, hb_data_d;
  logic [TRAIL_BYTES-1:0] hb_vld_q, hb_vld_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   rx_sot_q, rx_sot_d;
  logic                   rx_eot_q, rx_eot_d;
  logic                   rx_sot_err_q, rx_sot_err_d;
  logic                   active_q, active_d;
  logic [7:0]             err_cnt_q, err_cnt_d;

  logic        found, mismatch;
  logic [2:0]  offset;
  logic [15:0] window;
  logic [7:0]  aligned;

  dsi_sync_finder u_sync_finder (
    .prev_q   (prev_q),
    .hs_input (hs_input),
    .found    (found),
    .mismatch (mismatch),
    .offset   (offset)
  );

  assign window  = {hs_input, prev_q};
  assign aligned = window[off_q +: 8];

  always_comb begin
    state_d      = state_q;
    prev_d       = hs_valid ? hs_input : prev_q;
    off_d        = off_q;
    hunt_cnt_d   = hunt_cnt_q;
    hb_data_d    = hb_data_q;
    hb_vld_d     = hb_vld_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    rx_sot_d     = 1'b0;
    rx_eot_d     = 1'b0;
    rx_sot_err_d = 1'b0;
    err_cnt_d    = err_cnt_q;

    case (state_q)
      RX_IDLE: begin
        prev_d     = 8'd0;
        hunt_cnt_d = '0;
        hb_vld_d   = '0;
        if (hs_valid) state_d = RX_HUNT;
      end
      RX_HUNT: begin
        // Lock takes priority over timeout; a falling hs_valid beats both.
        if (!hs_valid) begin
          state_d = RX_IDLE;
        end else if (found) begin
          off_d    = offset;
          rx_sot_d = 1'b1;
          state_d  = RX_ACTIVE;
        end else if (mismatch || (hunt_cnt_q == HUNT_LAST)) begin
          rx_sot_err_d = 1'b1;
          state_d      = RX_ERR;
        end else begin
          hunt_cnt_d = hunt_cnt_q + 1'b1;
        end
      end
      RX_ACTIVE: begin
        if (!hs_valid) begin
          hb_vld_d = '0;
          rx_eot_d = 1'b1;
          state_d  = RX_IDLE;
        end else begin
          if (hb_vld_q[TRAIL_BYTES-1]) begin
            rx_data_d  = hb_data_q[HB_W-1 -: 8];
            rx_valid_d = 1'b1;
          end
          hb_data_d       = hb_data_q << 8;
          hb_data_d[7:0]  = aligned;
          hb_vld_d        = hb_vld_q << 1;
          hb_vld_d[0]     = 1'b1;
        end
      end
      RX_ERR: begin
        if (!hs_valid) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase

    if (rx_sot_err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
    active_d = (state_d != RX_IDLE);
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RX_IDLE;
      prev_q       <= 8'd0;
      off_q        <= 3'd0;
      hunt_cnt_q   <= '0;
      hb_data_q    <= '0;
      hb_vld_q     <= '0;
      rx_data_q    <= 8'd0;
      rx_valid_q   <= 1'b0;
      rx_sot_q     <= 1'b0;
      rx_eot_q     <= 1'b0;
      rx_sot_err_q <= 1'b0;
      active_q     <= 1'b0;
      err_cnt_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      off_q        <= off_d;
      hunt_cnt_q   <= hunt_cnt_d;
      hb_data_q    <= hb_data_d;
      hb_vld_q     <= hb_vld_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_sot_q     <= rx_sot_d;
      rx_eot_q     <= rx_eot_d;
      rx_sot_err_q <= rx_sot_err_d;
      active_q     <= active_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_sot      = rx_sot_q;
  assign rx_eot      = rx_eot_q;
  assign rx_sot_err  = rx_sot_err_q;
  assign active      = active_q;
  assign sot_err_cnt = err_cnt_q;

endmodule
`default_nettype wire
